// File: rtl/io_pkg.sv
// Shared encodings and helpers for the OTTER I/O bus output path.
// Holds the store-size codes, port stride, default base address and lane helpers.
package io_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } ioSize_t;

  localparam int          IO_PORT_STRIDE       = 4;
  localparam logic [31:0] IO_BASE_ADDR_DEFAULT = 32'h1100_C000;

  // Byte enables for a store of the given size starting at the given lane.
  function automatic logic [3:0] laneEnables(input ioSize_t size, input logic [1:0] lane);
    logic [3:0] en;
    en = 4'b0000;
    case (size)
      SIZE_BYTE: en = 4'b0001 << lane;
      SIZE_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: en = 4'b1111;
      default:   en = 4'b0000;
    endcase
    return en;
  endfunction

  function automatic logic isMisaligned(input ioSize_t size, input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = (lane != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational merge of right-aligned store data into an existing 32-bit word.
// Also flags stores whose size/lane combination cannot be honoured.
module byte_lane_merge
  import io_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] storeData,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] mergedWord,
  output logic        misalign
);

  ioSize_t     sizeEnc;
  logic [3:0]  byteEn;
  logic [31:0] alignedData;

  assign sizeEnc     = ioSize_t'(size);
  assign byteEn      = laneEnables(sizeEnc, lane);
  assign misalign    = isMisaligned(sizeEnc, lane);
  assign alignedData = storeData << {lane, 3'b000};

  // Misaligned results are never written, so no special case is needed here.
  always_comb begin
    mergedWord = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (byteEn[b]) begin
        mergedWord[8*b +: 8] = alignedData[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/io_out_demux.sv
// OTTER I/O bus output router: decodes stores into N_PORTS registered 32-bit ports.
// Optional readback of port contents is built only when IO_READBACK_EN is defined.
module io_out_demux
  import io_pkg::*;
#(
  parameter int          N_PORTS   = 4,
  parameter logic [31:0] BASE_ADDR = IO_BASE_ADDR_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [31:0]            IOBUS_ADDR,
  input  logic [31:0]            IOBUS_OUT,
  input  logic                   IOBUS_WR,
  input  logic [1:0]             IOBUS_SIZE,
  input  logic                   IOBUS_RD,
  output logic [32*N_PORTS-1:0]  PORT_DATA,
  output logic [N_PORTS-1:0]     PORT_STB,
  output logic                   ADDR_ERR,
  output logic [31:0]            RD_DATA
);

  localparam int          IDX_W        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [31:0] WINDOW_BYTES = 32'(IO_PORT_STRIDE * N_PORTS);

  logic [31:0]        addrOffset;
  logic               addrHit;
  logic [IDX_W-1:0]   portIdx;
  logic [1:0]         lane;
  logic [31:0]        portRegs [N_PORTS];
  logic [31:0]        selWord;
  logic [31:0]        mergedWord;
  logic               misalign;
  logic               storeOk;
  logic               storeReject;
  logic [N_PORTS-1:0] portSel;
  logic [N_PORTS-1:0] stbReg;
  logic               errReg;

  // The lower-bound test guards against the subtraction wrapping for low addresses.
  assign addrOffset = IOBUS_ADDR - BASE_ADDR;
  assign addrHit    = (IOBUS_ADDR >= BASE_ADDR) && (addrOffset < WINDOW_BYTES);
  assign portIdx    = addrOffset[IDX_W+1:2];
  assign lane       = IOBUS_ADDR[1:0];

  always_comb begin
    selWord = '0;
    portSel = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (portIdx == IDX_W'(k)) begin
        selWord    = portRegs[k];
        portSel[k] = storeOk;
      end
    end
  end

  byte_lane_merge u_merge (
    .oldWord    (selWord),
    .storeData  (IOBUS_OUT),
    .size       (IOBUS_SIZE),
    .lane       (lane),
    .mergedWord (mergedWord),
    .misalign   (misalign)
  );

  assign storeOk     = IOBUS_WR && addrHit && !misalign;
  assign storeReject = IOBUS_WR && addrHit && misalign;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < N_PORTS; k++) begin
        portRegs[k] <= '0;
      end
      stbReg <= '0;
      errReg <= 1'b0;
    end else begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (portSel[k]) begin
          portRegs[k] <= mergedWord;
        end
      end
      stbReg <= portSel;
      errReg <= storeReject;
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_portOut
    assign PORT_DATA[32*g +: 32] = portRegs[g];
  end

  assign PORT_STB = stbReg;
  assign ADDR_ERR = errReg;

`ifdef IO_READBACK_EN
  logic [31:0] rdReg;

  // selWord is the pre-store value, so a coincident write reads the old contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdReg <= '0;
    end else begin
      rdReg <= (IOBUS_RD && addrHit) ? selWord : '0;
    end
  end

  assign RD_DATA = rdReg;
`else
  logic unusedRd;

  assign unusedRd = IOBUS_RD;
  assign RD_DATA  = '0;
`endif

endmodule

// File: tb/tb_io_out_demux.sv
// Self-checking bench for io_out_demux with a scoreboard of expected port state.
// Readback expectations follow IO_READBACK_EN when the bench is built with it.
module tb_io_out_demux;
  import io_pkg::*;

  localparam int          N_PORTS = 4;
  localparam logic [31:0] BASE    = IO_BASE_ADDR_DEFAULT;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b0;
  logic [31:0]           IOBUS_ADDR = '0;
  logic [31:0]           IOBUS_OUT = '0;
  logic                  IOBUS_WR = 1'b0;
  logic [1:0]            IOBUS_SIZE = 2'b00;
  logic                  IOBUS_RD = 1'b0;
  logic [32*N_PORTS-1:0] PORT_DATA;
  logic [N_PORTS-1:0]    PORT_STB;
  logic                  ADDR_ERR;
  logic [31:0]           RD_DATA;

  typedef struct {
    string                 tag;
    logic [32*N_PORTS-1:0] portData;
    logic [N_PORTS-1:0]    portStb;
    logic                  addrErr;
    logic [31:0]           rdData;
  } expect_t;

  expect_t     sbQueue[$];
  logic [31:0] modelPorts [N_PORTS];
  int          checkCount = 0;
  int          passCount  = 0;
  int          failCount  = 0;

  io_out_demux #(.N_PORTS(N_PORTS), .BASE_ADDR(BASE)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_SIZE (IOBUS_SIZE),
    .IOBUS_RD   (IOBUS_RD),
    .PORT_DATA  (PORT_DATA),
    .PORT_STB   (PORT_STB),
    .ADDR_ERR   (ADDR_ERR),
    .RD_DATA    (RD_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic compareVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    expect_t e;
    if (sbQueue.size() == 0) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sbQueue.pop_front();
      compareVal({e.tag, ".data"}, 128'(PORT_DATA), 128'(e.portData));
      compareVal({e.tag, ".stb"},  128'(PORT_STB),  128'(e.portStb));
      compareVal({e.tag, ".err"},  128'(ADDR_ERR),  128'(e.addrErr));
      compareVal({e.tag, ".rd"},   128'(RD_DATA),   128'(e.rdData));
    end
  endtask

  // Directed constant check of one port against a value worked out by hand.
  task automatic checkPort(input string tag, input int idx, input logic [31:0] value);
    compareVal(tag, 128'(PORT_DATA[32*idx +: 32]), 128'(value));
  endtask

  task automatic applyStimulus(input string tag, input logic rst, input logic wr, input logic rd,
                               input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    expect_t    e;
    logic       hit;
    int         idx;
    int         lane;
    logic [3:0] be;
    logic       bad;
`ifdef IO_READBACK_EN
    logic [31:0] preRead;
`endif
    RST        = rst;
    IOBUS_WR   = wr;
    IOBUS_RD   = rd;
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_SIZE = size;

    hit  = (addr >= BASE) && ((addr - BASE) < 32'(4 * N_PORTS));
    idx  = hit ? int'((addr - BASE) / 4) : 0;
    lane = int'(addr % 4);
    e.tag     = tag;
    e.portStb = '0;
    e.addrErr = 1'b0;
    e.rdData  = '0;
`ifdef IO_READBACK_EN
    preRead = hit ? modelPorts[idx] : 32'h0;
`endif
    if (rst) begin
      for (int k = 0; k < N_PORTS; k++) modelPorts[k] = '0;
    end else begin
      if (wr && hit) begin
        be  = 4'b0000;
        bad = 1'b1;
        case (size)
          2'b00: begin be = 4'b0001 << lane; bad = 1'b0; end
          2'b01: begin be = 4'b0011 << lane; bad = (lane % 2) != 0; end
          2'b10: begin be = 4'b1111;         bad = (lane != 0); end
          default: bad = 1'b1;
        endcase
        if (bad) begin
          e.addrErr = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) modelPorts[idx][8*b +: 8] = data[8*(b-lane) +: 8];
          end
          e.portStb[idx] = 1'b1;
        end
      end
`ifdef IO_READBACK_EN
      if (rd && hit) e.rdData = preRead;
`endif
    end
    for (int k = 0; k < N_PORTS; k++) e.portData[32*k +: 32] = modelPorts[k];
    sbQueue.push_back(e);

    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  initial begin
    for (int k = 0; k < N_PORTS; k++) modelPorts[k] = '0;
    #2;
    $display("[TB] starting io_out_demux checks");

    applyStimulus("reset_wr",   1, 1, 1, BASE,        32'hFFFF_FFFF, SIZE_WORD);
    applyStimulus("reset_hold", 1, 1, 0, BASE + 8,    32'h1234_5678, SIZE_WORD);

    applyStimulus("word_p2",    0, 1, 0, BASE + 8,    32'hDEAD_BEEF, SIZE_WORD);
    checkPort("word_p2.const", 2, 32'hDEAD_BEEF);
    compareVal("word_p2.stbconst", 128'(PORT_STB), 128'(4'b0100));
    applyStimulus("idle_after", 0, 0, 0, BASE + 8,    32'h0,         SIZE_WORD);

    applyStimulus("word_p1",    0, 1, 0, BASE + 4,    32'h1122_3344, SIZE_WORD);
    applyStimulus("byte_p1",    0, 1, 0, BASE + 6,    32'h0000_00AA, SIZE_BYTE);
    checkPort("byte_p1.const", 1, 32'h11AA_3344);
    applyStimulus("half_p1",    0, 1, 0, BASE + 4,    32'h0000_5566, SIZE_HALF);
    checkPort("half_p1.const", 1, 32'h11AA_5566);
    applyStimulus("half_upper", 0, 1, 0, BASE + 14,   32'hFFFF_C0DE, SIZE_HALF);
    applyStimulus("byte_lane3", 0, 1, 0, BASE + 11,   32'h0000_0077, SIZE_BYTE);

    applyStimulus("half_mis",   0, 1, 0, BASE + 1,    32'h0000_BBBB, SIZE_HALF);
    compareVal("half_mis.errconst", 128'(ADDR_ERR), 128'(1'b1));
    applyStimulus("err_clear",  0, 0, 0, BASE,        32'h0,         SIZE_WORD);
    applyStimulus("word_mis",   0, 1, 0, BASE + 2,    32'hCCCC_CCCC, SIZE_WORD);
    applyStimulus("rsvd_size",  0, 1, 0, BASE,        32'hCCCC_CCCC, SIZE_RSVD);
    applyStimulus("miss_above", 0, 1, 0, BASE + 16,   32'h9999_9999, SIZE_WORD);
    applyStimulus("miss_below", 0, 1, 0, BASE - 1,    32'h9999_9999, SIZE_BYTE);
    applyStimulus("miss_mis",   0, 1, 0, BASE + 17,   32'h9999_9999, SIZE_HALF);

    applyStimulus("b2b_p0",     0, 1, 0, BASE,        32'hA5A5_0001, SIZE_WORD);
    compareVal("b2b_p0.stbconst", 128'(PORT_STB), 128'(4'b0001));
    applyStimulus("b2b_p3",     0, 1, 0, BASE + 12,   32'h5A5A_0003, SIZE_WORD);
    compareVal("b2b_p3.stbconst", 128'(PORT_STB), 128'(4'b1000));
    applyStimulus("b2b_p3_again", 0, 1, 0, BASE + 12, 32'h0000_0042, SIZE_BYTE);
    applyStimulus("b2b_idle",   0, 0, 0, BASE,        32'h0,         SIZE_WORD);

    applyStimulus("rb_write",   0, 1, 0, BASE,        32'h0000_00FF, SIZE_WORD);
    applyStimulus("rb_read",    0, 0, 1, BASE + 3,    32'h0,         SIZE_BYTE);
`ifdef IO_READBACK_EN
    compareVal("rb_read.const", 128'(RD_DATA), 128'(32'h0000_00FF));
`else
    compareVal("rb_read.const", 128'(RD_DATA), 128'(32'h0));
`endif
    applyStimulus("rb_miss",    0, 0, 1, BASE + 16,   32'h0,         SIZE_WORD);
    applyStimulus("rb_wr_rd",   0, 1, 1, BASE + 8,    32'h0BAD_F00D, SIZE_WORD);
    applyStimulus("rb_idle",    0, 0, 0, BASE + 8,    32'h0,         SIZE_WORD);

    applyStimulus("reset_late", 1, 1, 1, BASE + 4,    32'hFFFF_FFFF, SIZE_WORD);
    applyStimulus("post_reset", 0, 0, 0, BASE,        32'h0,         SIZE_WORD);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
